text_cursor_writer: RTL and testbench



---
 rtl/text_cursor_writer.sv | 179 +++++++++++++++++
 tb/tb_text_cursor_writer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_writer.sv
// Converts received UART bytes into text-RAM write commands and tracks the cursor.
// Handles printable characters, CR/LF newlines, backspace and a full-screen clear sweep.
module text_cursor_writer #(
   parameter int         COL_W      = 5,
   parameter int         ROW_W      = 2,
   parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             clear_req,
   output logic             wr_en,
   output logic [ROW_W-1:0] wr_row,
   output logic [COL_W-1:0] wr_col,
   output logic [7:0]       wr_data,
   output logic [ROW_W-1:0] cursor_row,
   output logic [COL_W-1:0] cursor_col,
   output logic             busy,
   output logic             overflow
);

   localparam int CELL_W = ROW_W + COL_W;
   localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
   localparam logic [CELL_W-1:0] CELL_ONE = CELL_W'(1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic              pend_valid;
   logic [7:0]        pend_data;
   logic              last_was_cr;
   logic [CELL_W-1:0] sweep_cnt;

   logic       src_valid;
   logic [7:0] src_byte;
   logic       src_print;
   logic       start_clear;

   // A byte held over from a sweep takes priority over the live receiver byte.
   always_comb begin
      src_valid   = 1'b0;
      src_byte    = rx_data;
      if (state == IDLE) begin
         src_valid = pend_valid || rx_valid;
         src_byte  = pend_valid ? pend_data : rx_data;
      end
      src_print   = (src_byte >= 8'h20) && (src_byte <= 8'h7E);
      start_clear = (state == IDLE) && (clear_req || (src_valid && (src_byte == 8'h0C)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pend_valid  <= 1'b0;
         pend_data   <= '0;
         last_was_cr <= 1'b0;
         sweep_cnt   <= '0;
         wr_en       <= 1'b0;
         wr_row      <= '0;
         wr_col      <= '0;
         wr_data     <= '0;
         cursor_row  <= '0;
         cursor_col  <= '0;
         busy        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         overflow <= 1'b0;
         case (state)
            IDLE: begin
               // An external clear keeps any held byte and parks the live one for after the sweep.
               if (clear_req) begin
                  if (rx_valid) begin
                     if (pend_valid) begin
                        overflow <= 1'b1;
                     end else begin
                        pend_valid <= 1'b1;
                        pend_data  <= rx_data;
                     end
                  end
               end else if (pend_valid) begin
                  pend_valid <= rx_valid;
                  if (rx_valid) begin
                     pend_data <= rx_data;
                  end
               end

               if (start_clear) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  wr_en     <= 1'b1;
                  wr_row    <= '0;
                  wr_col    <= '0;
                  wr_data   <= CLEAR_CHAR;
                  sweep_cnt <= CELL_ONE;
                  if (!clear_req) begin
                     last_was_cr <= 1'b0;
                  end
               end else if (src_valid) begin
                  if (src_print) begin
                     wr_en       <= 1'b1;
                     wr_row      <= cursor_row;
                     wr_col      <= cursor_col;
                     wr_data     <= src_byte;
                     cursor_col  <= cursor_col + COL_ONE;
                     last_was_cr <= 1'b0;
                     if (cursor_col == '1) begin
                        cursor_row <= cursor_row + ROW_ONE;
                     end
                  end else begin
                     case (src_byte)
                        8'h0D: begin
                           cursor_col  <= '0;
                           cursor_row  <= cursor_row + ROW_ONE;
                           last_was_cr <= 1'b1;
                        end
                        8'h0A: begin
                           if (!last_was_cr) begin
                              cursor_col <= '0;
                              cursor_row <= cursor_row + ROW_ONE;
                           end
                           last_was_cr <= 1'b0;
                        end
                        8'h08, 8'h7F: begin
                           // Backspace steps back across a row boundary but never past the home cell.
                           if (cursor_col != '0) begin
                              cursor_col <= cursor_col - COL_ONE;
                              wr_en      <= 1'b1;
                              wr_row     <= cursor_row;
                              wr_col     <= cursor_col - COL_ONE;
                              wr_data    <= CLEAR_CHAR;
                           end else if (cursor_row != '0) begin
                              cursor_row <= cursor_row - ROW_ONE;
                              cursor_col <= '1;
                              wr_en      <= 1'b1;
                              wr_row     <= cursor_row - ROW_ONE;
                              wr_col     <= '1;
                              wr_data    <= CLEAR_CHAR;
                           end
                           last_was_cr <= 1'b0;
                        end
                        default: begin
                        end
                     endcase
                  end
               end
            end

            CLEAR: begin
               // The counter wraps to zero once the last cell has been issued.
               if (sweep_cnt == '0) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  cursor_row <= '0;
                  cursor_col <= '0;
               end else begin
                  wr_en             <= 1'b1;
                  {wr_row, wr_col}  <= sweep_cnt;
                  wr_data           <= CLEAR_CHAR;
                  sweep_cnt         <= sweep_cnt + CELL_ONE;
               end
               if (rx_valid) begin
                  if (pend_valid) begin
                     overflow <= 1'b1;
                  end else begin
                     pend_valid <= 1'b1;
                     pend_data  <= rx_data;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Bench for text_cursor_writer: directed scenarios plus random traffic, each checked against
// a linear-position screen model with a queue for held-over bytes.
module tb_text_cursor_writer;

   localparam int COLS  = 32;
   localparam int ROWS  = 4;
   localparam int CELLS = COLS * ROWS;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       clear_req = 1'b0;
   logic       wr_en;
   logic [1:0] wr_row;
   logic [4:0] wr_col;
   logic [7:0] wr_data;
   logic [1:0] cursor_row;
   logic [4:0] cursor_col;
   logic       busy;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   int         m_pos;
   bit         m_cr;
   int         m_sweep;
   logic [7:0] m_q[$];
   bit         e_wr;
   bit         e_busy;
   bit         e_ovf;
   int         e_pos;
   logic [7:0] e_data;

   always #5 clk = ~clk;

   text_cursor_writer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .clear_req  (clear_req),
      .wr_en      (wr_en),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .wr_data    (wr_data),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy),
      .overflow   (overflow)
   );

   function automatic logic [24:0] obs_vec();
      return {wr_en, wr_en ? wr_row : 2'd0, wr_en ? wr_col : 5'd0, wr_en ? wr_data : 8'd0,
              cursor_row, cursor_col, busy, overflow};
   endfunction

   function automatic logic [24:0] exp_vec();
      logic [1:0] r;
      logic [4:0] c;
      logic [7:0] d;
      r = e_wr ? 2'(e_pos / COLS) : 2'd0;
      c = e_wr ? 5'(e_pos % COLS) : 5'd0;
      d = e_wr ? e_data : 8'd0;
      return {e_wr, r, c, d, 2'(m_pos / COLS), 5'(m_pos % COLS), e_busy, e_ovf};
   endfunction

   task automatic model_reset();
      m_pos = 0; m_cr = 1'b0; m_sweep = -1; m_q.delete();
      e_wr = 1'b0; e_busy = 1'b0; e_ovf = 1'b0; e_pos = 0; e_data = 8'h00;
   endtask

   task automatic model_write(input int pos, input logic [7:0] d);
      e_wr = 1'b1; e_pos = pos; e_data = d;
   endtask

   task automatic model_start_sweep();
      model_write(0, 8'h20);
      e_busy  = 1'b1;
      m_sweep = 1;
   endtask

   task automatic model_park(input bit v, input logic [7:0] d);
      if (v) begin
         if (m_q.size() == 0) m_q.push_back(d);
         else e_ovf = 1'b1;
      end
   endtask

   task automatic model_decode(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         model_write(m_pos, b);
         m_pos = (m_pos + 1) % CELLS;
         m_cr  = 1'b0;
      end else if (b == 8'h0D) begin
         m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
         m_cr  = 1'b1;
      end else if (b == 8'h0A) begin
         if (!m_cr) m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
         m_cr = 1'b0;
      end else if (b == 8'h08 || b == 8'h7F) begin
         if (m_pos > 0) begin
            m_pos = m_pos - 1;
            model_write(m_pos, 8'h20);
         end
         m_cr = 1'b0;
      end else if (b == 8'h0C) begin
         model_start_sweep();
         m_cr = 1'b0;
      end
   endtask

   task automatic model_edge(input bit v, input logic [7:0] d, input bit c);
      logic [7:0] b;
      e_wr  = 1'b0;
      e_ovf = 1'b0;
      if (m_sweep >= 0) begin
         if (m_sweep == CELLS) begin
            m_sweep = -1; m_pos = 0; e_busy = 1'b0;
         end else begin
            model_write(m_sweep, 8'h20);
            m_sweep++;
         end
         model_park(v, d);
      end else if (c) begin
         model_start_sweep();
         model_park(v, d);
      end else if (m_q.size() > 0) begin
         b = m_q.pop_front();
         if (v) m_q.push_back(d);
         model_decode(b);
      end else if (v) begin
         model_decode(d);
      end
   endtask

   task automatic cyc(input bit v, input logic [7:0] d, input bit c);
      rx_valid = v; rx_data = d; clear_req = c;
      @(posedge clk);
      model_edge(v, d, c);
      #1;
      rx_valid = 1'b0; clear_req = 1'b0;
   endtask

   task automatic apply_reset();
      rx_valid = 1'b0; clear_req = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (obs_vec() !== 25'd0) begin
         bad++; $display("[TB] FAIL reset_hold: got %h want %h", obs_vec(), 25'd0);
      end
      rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++; $display("[TB] FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_print();
      logic [7:0] seq[2];
      seq[0] = 8'h41; seq[1] = 8'h42;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, seq[i], 1'b0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL print_%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
         total++;
         if ({wr_en, wr_row, wr_col, wr_data} !== {1'b1, 2'd0, 5'(i), seq[i]}) begin
            bad++; $display("[TB] FAIL print_cell_%0d: got %b/%0d/%0d/%h want 1/0/%0d/%h",
                            i, wr_en, wr_row, wr_col, wr_data, i, seq[i]);
         end
      end
      cyc(1'b0, 8'h00, 1'b0);
      total++;
      if ({wr_en, cursor_row, cursor_col} !== {1'b0, 2'd0, 5'd2}) begin
         bad++; $display("[TB] FAIL print_end: got wr=%b cur=(%0d,%0d) want wr=0 cur=(0,2)",
                         wr_en, cursor_row, cursor_col);
      end
   endtask

   task automatic test_wrap_newline();
      apply_reset();
      for (int i = 0; i < CELLS - 1; i++) begin
         cyc(1'b1, 8'h78, 1'b0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL fill_%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      cyc(1'b1, 8'h58, 1'b0);
      total++;
      if ({wr_en, wr_row, wr_col, wr_data, cursor_row, cursor_col} !==
          {1'b1, 2'd3, 5'd31, 8'h58, 2'd0, 5'd0}) begin
         bad++; $display("[TB] FAIL wrap: got wr=%b (%0d,%0d)=%h cur=(%0d,%0d) want wr=1 (3,31)=58 cur=(0,0)",
                         wr_en, wr_row, wr_col, wr_data, cursor_row, cursor_col);
      end
      cyc(1'b1, 8'h0D, 1'b0);
      cyc(1'b1, 8'h0A, 1'b0);
      total++;
      if ({wr_en, cursor_row, cursor_col} !== {1'b0, 2'd1, 5'd0}) begin
         bad++; $display("[TB] FAIL crlf: got wr=%b cur=(%0d,%0d) want wr=0 cur=(1,0)",
                         wr_en, cursor_row, cursor_col);
      end
      cyc(1'b1, 8'h0A, 1'b0);
      total++;
      if (obs_vec() !== exp_vec() || {cursor_row, cursor_col} !== {2'd2, 5'd0}) begin
         bad++; $display("[TB] FAIL lone_lf: got cur=(%0d,%0d) want cur=(2,0)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_backspace();
      apply_reset();
      cyc(1'b1, 8'h0D, 1'b0);
      cyc(1'b1, 8'h08, 1'b0);
      total++;
      if ({wr_en, wr_row, wr_col, wr_data, cursor_row, cursor_col} !==
          {1'b1, 2'd0, 5'd31, 8'h20, 2'd0, 5'd31}) begin
         bad++; $display("[TB] FAIL bs_wrap: got wr=%b (%0d,%0d)=%h cur=(%0d,%0d) want wr=1 (0,31)=20 cur=(0,31)",
                         wr_en, wr_row, wr_col, wr_data, cursor_row, cursor_col);
      end
      cyc(1'b1, 8'h7F, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++; $display("[TB] FAIL del: got %h want %h", obs_vec(), exp_vec());
      end
      apply_reset();
      cyc(1'b1, 8'h08, 1'b0);
      total++;
      if ({wr_en, cursor_row, cursor_col} !== {1'b0, 2'd0, 5'd0}) begin
         bad++; $display("[TB] FAIL bs_home: got wr=%b cur=(%0d,%0d) want wr=0 cur=(0,0)",
                         wr_en, cursor_row, cursor_col);
      end
   endtask

   task automatic test_clear();
      int writes;
      apply_reset();
      cyc(1'b1, 8'h41, 1'b0);
      cyc(1'b1, 8'h0D, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      writes = wr_en ? 1 : 0;
      total++;
      if ({busy, wr_en, wr_row, wr_col, wr_data} !== {1'b1, 1'b1, 2'd0, 5'd0, 8'h20}) begin
         bad++; $display("[TB] FAIL clear_entry: got busy=%b wr=%b (%0d,%0d)=%h want busy=1 wr=1 (0,0)=20",
                         busy, wr_en, wr_row, wr_col, wr_data);
      end
      for (int i = 1; i < CELLS + 2; i++) begin
         cyc(1'b0, 8'h00, (i == 20));
         if (wr_en) writes++;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL sweep_%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      total++;
      if (writes !== CELLS || {busy, cursor_row, cursor_col} !== {1'b0, 2'd0, 5'd0}) begin
         bad++; $display("[TB] FAIL sweep_total: got writes=%0d busy=%b cur=(%0d,%0d) want writes=128 busy=0 cur=(0,0)",
                         writes, busy, cursor_row, cursor_col);
      end
   endtask

   task automatic test_pending();
      int ovf_count;
      bit saw_a;
      ovf_count = 0;
      saw_a = 1'b0;
      apply_reset();
      cyc(1'b0, 8'h00, 1'b1);
      for (int i = 1; i < CELLS + 6; i++) begin
         cyc((i == 10) || (i == 30), (i == 10) ? 8'h41 : 8'h42, 1'b0);
         if (overflow) ovf_count++;
         if (!busy && wr_en && {wr_row, wr_col, wr_data} === {2'd0, 5'd0, 8'h41}) saw_a = 1'b1;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL pend_%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      total++;
      if (ovf_count !== 1 || saw_a !== 1'b1) begin
         bad++; $display("[TB] FAIL pend_summary: got ovf=%0d a_written=%b want ovf=1 a_written=1",
                         ovf_count, saw_a);
      end
   endtask

   task automatic test_reset_mid_clear();
      apply_reset();
      cyc(1'b0, 8'h00, 1'b1);
      for (int i = 1; i <= 50; i++) begin
         cyc(1'b0, 8'h00, 1'b0);
      end
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++; $display("[TB] FAIL cell50: got %h want %h", obs_vec(), exp_vec());
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (obs_vec() !== 25'd0) begin
         bad++; $display("[TB] FAIL abort: got %h want %h", obs_vec(), 25'd0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(1'b1, 8'h41, 1'b0);
      total++;
      if ({wr_en, wr_row, wr_col, wr_data, busy} !== {1'b1, 2'd0, 5'd0, 8'h41, 1'b0}) begin
         bad++; $display("[TB] FAIL after_abort: got wr=%b (%0d,%0d)=%h busy=%b want wr=1 (0,0)=41 busy=0",
                         wr_en, wr_row, wr_col, wr_data, busy);
      end
   endtask

   task automatic test_random();
      bit         v;
      bit         c;
      logic [7:0] d;
      int         pick;
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
         v    = ($urandom_range(0, 9) < 4);
         c    = ($urandom_range(0, 199) == 0);
         pick = $urandom_range(0, 19);
         if (pick < 9)       d = 8'($urandom_range(32, 126));
         else if (pick < 11) d = 8'h0D;
         else if (pick < 13) d = 8'h0A;
         else if (pick < 15) d = 8'h08;
         else if (pick < 16) d = 8'h7F;
         else if (pick < 17) d = 8'($urandom_range(128, 255));
         else if (pick < 18) d = 8'($urandom_range(1, 7));
         else if (pick < 19) d = 8'h7E;
         else                d = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h20;
         cyc(v, d, c);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("[TB] FAIL rand_%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_print();
      test_wrap_newline();
      test_backspace();
      test_clear();
      test_pending();
      test_reset_mid_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
